// File: rtl/unified_mem_arbiter_if.sv
// Port bundle for unified_mem_arbiter: IF/MEM stage handshakes plus the external memory port.
// master = arbiter view, slave = pipeline + memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_adv;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              stall_if;
  logic              dm_rd_en;
  logic              dm_wr_en;
  logic [2:0]        dm_size;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              mem_adv;
  logic [31:0]       dm_rdata;
  logic              dm_valid;
  logic              dm_misalign;
  logic              stall_mem;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, if_adv, dm_rd_en, dm_wr_en, dm_size, dm_addr, dm_wdata,
           mem_adv, mem_rdata, mem_ack,
    output if_rdata, if_valid, stall_if, dm_rdata, dm_valid, dm_misalign, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr, if_adv, dm_rd_en, dm_wr_en, dm_size, dm_addr, dm_wdata,
           mem_adv, mem_rdata, mem_ack,
    input  if_rdata, if_valid, stall_if, dm_rdata, dm_valid, dm_misalign, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one handshaked unified memory between instruction fetch and load/store,
// formats byte/half/word accesses and produces the pipeline stall signals.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_misalign_q, dm_misalign_d;
  logic              dm_done_q, dm_done_d;
  logic              if_done_q, if_done_d;
  logic [2:0]        ld_size_q, ld_size_d;
  logic [1:0]        ld_lane_q, ld_lane_d;

  logic              dm_pend, if_pend, misalign;
  logic [1:0]        lane;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata, ld_shift, ld_result;
  logic              unused_if_lsb;

  assign unused_if_lsb = ^bus.if_addr[1:0];
  assign lane    = bus.dm_addr[1:0];
  assign dm_pend = (bus.dm_rd_en | bus.dm_wr_en) & ~dm_done_q;
  assign if_pend = bus.if_req & ~if_done_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    misalign = 1'b0;
    st_be    = 4'hF;
    st_wdata = bus.dm_wdata;
    case (bus.dm_size[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{bus.dm_wdata[7:0]}};
      end
      2'b01: begin
        misalign = lane[0];
        st_be    = 4'b0011 << {lane[1], 1'b0};
        st_wdata = {2{bus.dm_wdata[15:0]}};
      end
      default: misalign = |lane;
    endcase
  end

  // Load lane and size are captured at issue so the result never depends on live MEM inputs.
  assign ld_shift = bus.mem_rdata >> {ld_lane_q, 3'b000};

  always_comb begin
    ld_result = bus.mem_rdata;
    case (ld_size_q[1:0])
      2'b00:   ld_result = {{24{~ld_size_q[2] & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_result = {{16{~ld_size_q[2] & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_result = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    dm_rdata_d    = dm_rdata_q;
    if_rdata_d    = if_rdata_q;
    dm_valid_d    = 1'b0;
    if_valid_d    = 1'b0;
    dm_misalign_d = 1'b0;
    dm_done_d     = dm_done_q & ~bus.mem_adv;
    if_done_d     = if_done_q & ~bus.if_adv;
    ld_size_d     = ld_size_q;
    ld_lane_d     = ld_lane_q;

    case (state_q)
      IDLE: begin
        // A rejected misaligned access never occupies the port, so fetch may still start.
        if (dm_pend && misalign) begin
          dm_misalign_d = 1'b1;
          dm_done_d     = 1'b1;
          dm_rdata_d    = '0;
        end
        if (dm_pend && !misalign) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_wr_en;
          mem_addr_d  = {bus.dm_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = bus.dm_wr_en ? st_be : 4'hF;
          mem_wdata_d = bus.dm_wr_en ? st_wdata : '0;
          ld_size_d   = bus.dm_size;
          ld_lane_d   = lane;
        end else if (if_pend) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {bus.if_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = 4'hF;
          mem_wdata_d = '0;
        end
      end
      DATA: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          dm_done_d  = 1'b1;
          if (!mem_we_q) dm_rdata_d = ld_result;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_done_d  = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 4'h0;
      dm_rdata_q    <= '0;
      if_rdata_q    <= '0;
      dm_valid_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      dm_misalign_q <= 1'b0;
      dm_done_q     <= 1'b0;
      if_done_q     <= 1'b0;
      ld_size_q     <= 3'b000;
      ld_lane_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      dm_rdata_q    <= dm_rdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_valid_q    <= dm_valid_d;
      if_valid_q    <= if_valid_d;
      dm_misalign_q <= dm_misalign_d;
      dm_done_q     <= dm_done_d;
      if_done_q     <= if_done_d;
      ld_size_q     <= ld_size_d;
      ld_lane_q     <= ld_lane_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_valid    = dm_valid_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.dm_misalign = dm_misalign_q;
  assign bus.stall_mem   = dm_pend & ~dm_valid_q & ~dm_misalign_q;
  assign bus.stall_if    = if_pend & ~if_valid_q;

endmodule
